// File: rtl/irb_extmem_if.sv
// External-memory beat bus: one request/valid handshake per word.
interface irb_extmem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              request_extmem;
  logic              write_extmem;
  logic [ADDR_W-1:0] addr_extmem;
  logic [DATA_W-1:0] w_data;
  logic              valid_extmem;
  logic [DATA_W-1:0] data_extmem;

  modport master (
    output request_extmem, write_extmem, addr_extmem, w_data,
    input  valid_extmem, data_extmem
  );

  modport slave (
    input  request_extmem, write_extmem, addr_extmem, w_data,
    output valid_extmem, data_extmem
  );
endinterface

// File: rtl/irb_extmem_arbiter.sv
// Round-robin arbiter multiplexing N_CH DMA channels onto one external-memory
// beat bus. A granted channel owns the bus until its burst completes.
//
// state  | meaning
// IDLE   | waiting for a request; with grant_q set, the grant pulse cycle
// REQ    | beat request on the bus, waiting for valid_extmem
// GAP    | one idle bus cycle; rvalid/wready to the channel, done on last beat
module irb_extmem_arbiter #(
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_we,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*BL_W-1:0]     ch_len,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  output logic [N_CH-1:0]          ch_grant,
  output logic [N_CH-1:0]          ch_wready,
  output logic [N_CH-1:0]          ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_done,
  irb_extmem_if.master             mem
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   rem_q, rem_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_arr  [N_CH];
  logic [BL_W-1:0]   len_arr   [N_CH];
  logic [DATA_W-1:0] wdata_arr [N_CH];

  logic              found;
  logic [IDX_W-1:0]  win_idx;
  logic [BL_W-1:0]   eff_len;
  logic [N_CH-1:0]   sel;
  logic              req_o;
  int                cand;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]   = ch_len[g*BL_W +: BL_W];
    assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
  end

  assign sel = N_CH'(1) << idx_q;

  // Pick the first requester at or after rr_q, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (int'(rr_q) + k) % N_CH;
      if (!found && ch_req[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    eff_len = (len_arr[win_idx] > BL_W'(MAX_BURST)) ? BL_W'(MAX_BURST) : len_arr[win_idx];
  end

  // Next-state and per-cycle pulse outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    idx_d     = idx_q;
    rr_d      = rr_q;
    we_d      = we_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    zero_d    = zero_q;
    rdata_d   = rdata_q;
    req_o     = 1'b0;
    ch_grant  = '0;
    ch_rvalid = '0;
    ch_wready = '0;
    ch_done   = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_q) begin
          ch_grant = sel;
          state_d  = zero_q ? S_GAP : S_REQ;
        end else if (found) begin
          grant_d = 1'b1;
          idx_d   = win_idx;
          we_d    = ch_we[win_idx];
          addr_d  = addr_arr[win_idx];
          rem_d   = eff_len;
          zero_d  = (eff_len == '0);
        end
      end
      S_REQ: begin
        req_o = 1'b1;
        if (mem.valid_extmem) begin
          if (!we_q) rdata_d = mem.data_extmem;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!zero_q) begin
          if (we_q) ch_wready = sel;
          else      ch_rvalid = sel;
        end
        if (rem_q == '0) begin
          ch_done = sel;
          rr_d    = (idx_q == IDX_W'(N_CH - 1)) ? '0 : idx_q + 1'b1;
          zero_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      idx_q   <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      rdata_q <= rdata_d;
    end
  end

  assign ch_rdata           = rdata_q;
  assign mem.request_extmem = req_o;
  assign mem.write_extmem   = req_o & we_q;
  assign mem.addr_extmem    = req_o ? addr_q : '0;
  assign mem.w_data         = (req_o && we_q) ? wdata_arr[idx_q] : '0;
endmodule

// File: tb/tb_irb_extmem_arbiter.sv
`timescale 1ns/1ps
module tb_irb_extmem_arbiter;
  localparam int N_CH = 4, ADDR_W = 32, DATA_W = 32, MAX_BURST = 16, BL_W = 5;
  localparam int K_GRANT = 0, K_BEAT = 1, K_RVALID = 2, K_WREADY = 3, K_DONE = 4;

  typedef struct {
    int          kind;
    int          ch;
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    int          n;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_CH-1:0]        ch_req, ch_we;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*BL_W-1:0]   ch_len;
  logic [N_CH*DATA_W-1:0] ch_wdata;
  logic [N_CH-1:0]        ch_grant, ch_wready, ch_rvalid, ch_done;
  logic [DATA_W-1:0]      ch_rdata;

  irb_extmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  irb_extmem_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .MAX_BURST(MAX_BURST), .BL_W(BL_W)) dut (
    .clk(clk), .rst(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_grant(ch_grant), .ch_wready(ch_wready),
    .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ch_done(ch_done), .mem(mem_if)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, grant_cyc = 0, req_run = 0;
  int mem_delay = 0, wcnt = 0;
  int wbeat[N_CH];

  function automatic void push(int kind, int ch, logic [31:0] a, logic we, logic [31:0] d, int n);
    ev_t e;
    e.kind = kind; e.ch = ch; e.a = a; e.we = we; e.d = d; e.n = n;
    exp_q.push_back(e);
  endfunction

  function automatic int vec2ch(logic [N_CH-1:0] v);
    if (!$onehot(v)) return -1;
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic pop_cmp(input int kind, input int ch, input logic [31:0] a, input logic we,
                         input logic [31:0] d, input int n);
    ev_t e;
    bit ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d ch=%0d a=%h d=%h at cycle %0d, required none",
               kind, ch, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.kind == kind) && (e.ch == ch);
    if (kind == K_BEAT)
      ok = ok && (a === e.a) && (we === e.we) && (n == e.n) && (!e.we || d === e.d);
    if (kind == K_RVALID) ok = ok && (d === e.d);
    if (kind == K_DONE)   ok = ok && (n == e.n);
    if (!ok) begin
      errors++;
      $display("FAIL event_cycle%0d: got kind=%0d ch=%0d a=%h we=%0d d=%h n=%0d, required kind=%0d ch=%0d a=%h we=%0d d=%h n=%0d",
               cyc, kind, ch, a, we, d, n, e.kind, e.ch, e.a, e.we, e.d, e.n);
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_if.request_extmem) req_run++; else req_run = 0;
      if (ch_grant != '0) begin
        grant_cyc = cyc;
        pop_cmp(K_GRANT, vec2ch(ch_grant), '0, 1'b0, '0, 0);
      end
      if (mem_if.request_extmem && mem_if.valid_extmem)
        pop_cmp(K_BEAT, -1, mem_if.addr_extmem, mem_if.write_extmem, mem_if.w_data, req_run);
      if (ch_rvalid != '0) pop_cmp(K_RVALID, vec2ch(ch_rvalid), '0, 1'b0, ch_rdata, 0);
      if (ch_wready != '0) pop_cmp(K_WREADY, vec2ch(ch_wready), '0, 1'b0, '0, 0);
      if (ch_done != '0)   pop_cmp(K_DONE, vec2ch(ch_done), '0, 1'b0, '0, cyc - grant_cyc + 1);
    end
  end

  // External memory: acknowledges after mem_delay waiting cycles, read data = addr + 0xA000.
  initial begin
    mem_if.valid_extmem = 1'b0;
    mem_if.data_extmem  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || mem_if.valid_extmem) begin
        mem_if.valid_extmem = 1'b0;
        wcnt = 0;
      end else if (mem_if.request_extmem) begin
        if (wcnt >= mem_delay) begin
          mem_if.valid_extmem = 1'b1;
          mem_if.data_extmem  = mem_if.addr_extmem + 32'hA000;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Channel write-data sources: advance one word after each wready.
  initial begin
    logic [N_CH-1:0] seen;
    for (int c = 0; c < N_CH; c++) begin
      wbeat[c] = 0;
      ch_wdata[c*DATA_W +: DATA_W] = 32'hD000 + c*256;
    end
    forever begin
      @(negedge clk);
      seen = ch_wready;
      @(posedge clk); #1;
      for (int c = 0; c < N_CH; c++) begin
        if (seen[c]) wbeat[c]++;
        ch_wdata[c*DATA_W +: DATA_W] = 32'hD000 + c*256 + wbeat[c];
      end
    end
  end

  task automatic set_ch(input int c, input logic we, input logic [31:0] a, input int len);
    ch_we[c] = we;
    ch_addr[c*ADDR_W +: ADDR_W] = a;
    ch_len[c*BL_W +: BL_W] = BL_W'(len);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_grant == '0 && n < 100);
    if (ch_grant == '0) begin
      checks++; errors++;
      $display("FAIL %s_grant_timeout: got no grant in 100 cycles, required a grant", tag);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_done == '0 && n < 200);
    if (ch_done == '0) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got no done in 200 cycles, required a done", tag);
    end
  endtask

  task automatic xfer(input logic [N_CH-1:0] mask, input string tag);
    @(posedge clk); #1;
    ch_req = mask;
    wait_grant(tag);
    @(posedge clk); #1;
    ch_req = '0;
    wait_done(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_request", {31'd0, mem_if.request_extmem}, 32'd0);
    chk("reset_grant", {28'd0, ch_grant}, 32'd0);
    chk("reset_done", {28'd0, ch_done}, 32'd0);
    chk("reset_rdata", ch_rdata, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // All four channels, len 1: grants ch0,ch1,ch2,ch3,ch0.
    for (int c = 0; c < N_CH; c++) set_ch(c, 1'b0, 32'h300 + c*16, 1);
    for (int k = 0; k < 5; k++) begin
      push(K_GRANT,  k % 4, '0, 1'b0, '0, 0);
      push(K_BEAT,   -1, 32'h300 + (k % 4)*16, 1'b0, '0, 1);
      push(K_RVALID, k % 4, '0, 1'b0, 32'hA300 + (k % 4)*16, 0);
      push(K_DONE,   k % 4, '0, 1'b0, '0, 3);
    end
    @(posedge clk); #1;
    ch_req = 4'hF;
    for (int k = 0; k < 5; k++) wait_grant("rr");
    @(posedge clk); #1;
    ch_req = '0;
    wait_done("rr");

    // Read ch1, 0x100, len 3, zero-wait.
    set_ch(1, 1'b0, 32'h100, 3);
    push(K_GRANT, 1, '0, 1'b0, '0, 0);
    push(K_BEAT, -1, 32'h100, 1'b0, '0, 1); push(K_RVALID, 1, '0, 1'b0, 32'hA100, 0);
    push(K_BEAT, -1, 32'h101, 1'b0, '0, 1); push(K_RVALID, 1, '0, 1'b0, 32'hA101, 0);
    push(K_BEAT, -1, 32'h102, 1'b0, '0, 1); push(K_RVALID, 1, '0, 1'b0, 32'hA102, 0);
    push(K_DONE, 1, '0, 1'b0, '0, 7);
    xfer(4'b0010, "read3");

    // Write ch0, 0x200, len 2, memory waits 3 cycles per beat.
    mem_delay = 3;
    set_ch(0, 1'b1, 32'h200, 2);
    push(K_GRANT, 0, '0, 1'b0, '0, 0);
    push(K_BEAT, -1, 32'h200, 1'b1, 32'hD000, 4); push(K_WREADY, 0, '0, 1'b0, '0, 0);
    push(K_BEAT, -1, 32'h201, 1'b1, 32'hD001, 4); push(K_WREADY, 0, '0, 1'b0, '0, 0);
    push(K_DONE, 0, '0, 1'b0, '0, 11);
    xfer(4'b0001, "write2");
    mem_delay = 0;

    // ch2 len 20 clipped to 16 beats.
    set_ch(2, 1'b0, 32'h400, 20);
    push(K_GRANT, 2, '0, 1'b0, '0, 0);
    for (int k = 0; k < 16; k++) begin
      push(K_BEAT, -1, 32'h400 + k, 1'b0, '0, 1);
      push(K_RVALID, 2, '0, 1'b0, 32'hA400 + k, 0);
    end
    push(K_DONE, 2, '0, 1'b0, '0, 33);
    xfer(4'b0100, "clip16");

    // ch3 len 0: grant then done next cycle, no beat.
    set_ch(3, 1'b0, 32'h4F0, 0);
    push(K_GRANT, 3, '0, 1'b0, '0, 0);
    push(K_DONE, 3, '0, 1'b0, '0, 2);
    xfer(4'b1000, "zero");

    // Address wrap from 0xFFFFFFFF.
    set_ch(1, 1'b0, 32'hFFFF_FFFF, 2);
    push(K_GRANT, 1, '0, 1'b0, '0, 0);
    push(K_BEAT, -1, 32'hFFFF_FFFF, 1'b0, '0, 1); push(K_RVALID, 1, '0, 1'b0, 32'h0000_9FFF, 0);
    push(K_BEAT, -1, 32'h0000_0000, 1'b0, '0, 1); push(K_RVALID, 1, '0, 1'b0, 32'h0000_A000, 0);
    push(K_DONE, 1, '0, 1'b0, '0, 5);
    xfer(4'b0010, "wrap");

    // Reset during REQ on ch2; afterwards ch1 wins from rr_ptr 0.
    mem_delay = 5;
    set_ch(2, 1'b0, 32'h500, 4);
    push(K_GRANT, 2, '0, 1'b0, '0, 0);
    @(posedge clk); #1;
    ch_req = 4'b0100;
    wait_grant("midrst");
    @(posedge clk); #1;
    ch_req = '0;
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_request", {31'd0, mem_if.request_extmem}, 32'd0);
    chk("midrst_addr", mem_if.addr_extmem, 32'd0);
    chk("midrst_pulses", {16'd0, ch_grant, ch_rvalid, ch_wready, ch_done}, 32'd0);
    chk("midrst_rdata", ch_rdata, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    mem_delay = 0;
    rst_n = 1'b1;
    set_ch(1, 1'b0, 32'h600, 1);
    set_ch(2, 1'b0, 32'h700, 1);
    push(K_GRANT, 1, '0, 1'b0, '0, 0);
    push(K_BEAT, -1, 32'h600, 1'b0, '0, 1);
    push(K_RVALID, 1, '0, 1'b0, 32'hA600, 0);
    push(K_DONE, 1, '0, 1'b0, '0, 3);
    xfer(4'b0110, "postrst");

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irb_extmem_arbiter.md
# irb_extmem_arbiter

Parametrised external-memory port for the inverted residual block accelerator. It multiplexes N_CH independent DMA channels (feature-map loads, kernel loads, output write-back) onto the single request/valid external-memory interface. Channels are served with round-robin priority and transfer bursts of consecutive word addresses. It replaces the single-channel external path, so that loads and write-back for several tiles can be queued concurrently.

## Interface
Parameters:
- N_CH, 4: number of DMA channels (≥2).
- ADDR_W, 32: external word-address width.
- DATA_W, 32: data width.
- MAX_BURST, 16: maximum beats per grant.
- BL_W, $clog2(MAX_BURST+1): burst-length field width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_req  in  N_CH  per-channel transfer request (level).
- ch_we  in  N_CH  per-channel direction: 1 = write to external memory.
- ch_addr  in  N_CH*ADDR_W  per-channel start word address (packed, ch0 in LSBs).
- ch_len  in  N_CH*BL_W  per-channel burst length in beats.
- ch_wdata  in  N_CH*DATA_W  per-channel current write word.
- ch_grant  out  N_CH  one-cycle pulse when the channel wins arbitration.
- ch_wready  out  N_CH  one-cycle pulse when a write beat is accepted; the channel presents its next word on the following edge.
- ch_rvalid  out  N_CH  one-cycle pulse that qualifies ch_rdata.
- ch_rdata  out  DATA_W  read data, shared by all channels.
- ch_done  out  N_CH  one-cycle pulse at burst end.
- request_extmem  out  1  beat request to external memory.
- write_extmem  out  1  beat direction.
- addr_extmem  out  ADDR_W  beat address.
- w_data  out  DATA_W  beat write data.
- valid_extmem  in  1  external memory beat acknowledge (and read-data valid).
- data_extmem  in  DATA_W  read data, valid when valid_extmem = 1.

## Operation
States: IDLE, REQ, GAP.

IDLE
- If any ch_req bit is set, select the first requesting channel at or after rr_ptr, searching upward and wrapping.
- Latch the winner index, ch_we, ch_addr and the effective length, eff_len = min(ch_len, MAX_BURST).
- Pulse ch_grant[i] and go to REQ. If eff_len = 0, go to GAP with zero_burst set instead.

REQ
- Drive request_extmem = 1, write_extmem = latched we, addr_extmem = cur_addr, w_data = ch_wdata[i] (live).
- On valid_extmem = 1:
  - register data_extmem;
  - cur_addr <= cur_addr + 1 (modulo 2^ADDR_W, wraps silently);
  - remaining <= remaining - 1;
  - go to GAP.

GAP
- request_extmem = 0.
- Unless zero_burst is set: pulse ch_rvalid[i] with ch_rdata (read bursts) or ch_wready[i] (write bursts).
- If remaining = 0: pulse ch_done[i] in the same cycle, set rr_ptr <= (i+1) mod N_CH, clear zero_burst, go to IDLE. Otherwise return to REQ.

General rules
- valid_extmem outside REQ is ignored.
- ch_req is sampled only in IDLE. Dropping it before grant withdraws the request. If it stays high after done, it is a new transfer.
- Changes to ch_addr, ch_len and ch_we after grant have no effect.
- ch_rdata holds its last value between pulses.

## Timing
- Reset: all outputs 0, rr_ptr = 0, state IDLE, internal counters 0. A reset mid-burst abandons the burst with no done pulse.
- Grant latency: ch_grant is asserted the cycle after the state is IDLE with a request present, i.e. one edge after ch_req is seen.
- request_extmem rises the cycle after ch_grant.
- Per beat: request is held until the acknowledge cycle. rvalid/wready follow one cycle after valid_extmem. request_extmem stays low for exactly one cycle (GAP) between beats.
- Minimum beat period is 2 cycles (zero-wait memory).
- Minimum burst of n beats takes 1 + 2n cycles from grant to done. A zero-length burst pulses done 1 cycle after grant.
- Bursts are never interleaved. Only one channel is granted from grant to done.
- At most one bit of each ch_* pulse vector is high in any cycle.

## Test plan
- Single read, ch1, addr 0x100, len 3, zero-wait memory returning addr+0xA000 -> ch_grant=0010, addr_extmem 0x100/0x101/0x102, ch_rvalid[1] ×3 with rdata 0xA100/0xA101/0xA102, ch_done[1] with the 3rd rvalid, 7 cycles grant→done.
- Write ch0, len 2, valid_extmem delayed 3 cycles per beat, wdata advanced on each wready -> w_data correct per beat, request held 4 cycles per beat, write_extmem = 1.
- All four channels request continuously, len 1 -> grants in order ch0, ch1, ch2, ch3, ch0; no channel is granted twice before the others.
- ch_len = 20 with MAX_BURST = 16 -> exactly 16 beats then done. ch_len = 0 -> grant then done next cycle, no request_extmem.
- Start address 0xFFFFFFFF, len 2 -> second beat addresses 0x00000000.
- Assert rst low mid-burst during REQ -> all outputs 0 asynchronously. After release, the next request starts from rr_ptr = 0, with no spurious ch_done.
